// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI register target.
package spi_target_pkg;

    localparam int CMD_WRITE_BIT = 7;
    localparam int ADDR_W        = 7;
    localparam int DATA_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin, with a third history flop
// used to detect rising and falling edges of the synchronized level.
module spi_sync_edge #(
    parameter logic RESET_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic hist_r;

    // Synchronizer chain plus edge-history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_LVL;
            sync_r <= RESET_LVL;
            hist_r <= RESET_LVL;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            hist_r <= sync_r;
        end
    end

    assign lvl  = sync_r;
    assign rise = sync_r & ~hist_r;
    assign fall = ~sync_r & hist_r;

endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 register-file target: command byte (bit 7 write, 6:0 address)
// then data byte. Define SPI_TARGET_BURST_EN for auto-increment bursts.
module spi_reg_target
    import spi_target_pkg::*;
#(
    parameter int                NUM_REGS  = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       cs_n,
    input  logic                       mosi,
    output logic                       miso,
    output logic                       miso_oe,
    output logic [8*NUM_REGS-1:0]      regs_flat,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data
);

    logic sclk_lvl_unused_s, sclk_rise_s, sclk_fall_s;
    logic cs_lvl_s, cs_rise_unused_s, cs_fall_unused_s;
    logic mosi_lvl_s, mosi_rise_unused_s, mosi_fall_unused_s;

    spi_sync_edge #(.RESET_LVL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .lvl(sclk_lvl_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_sync_edge #(.RESET_LVL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_n),
        .lvl(cs_lvl_s), .rise(cs_rise_unused_s), .fall(cs_fall_unused_s)
    );
    spi_sync_edge #(.RESET_LVL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi),
        .lvl(mosi_lvl_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
    );

    state_t              state_r;
    logic [2:0]          bit_cnt_r;
    logic                done_r;
    logic [DATA_W-1:0]   shift_r;
    logic [DATA_W-1:0]   rd_shift_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                miso_r;
    logic                miso_oe_r;
    logic                wr_pulse_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [DATA_W-1:0]   wr_data_r;
    logic [DATA_W-1:0]   regs_r [NUM_REGS];

    logic [DATA_W-1:0]   shift_next_s;
    logic [DATA_W-1:0]   cmd_rd_s;
    logic                addr_hit_s;
    logic                last_rise_s;
    logic                wr_commit_s;
`ifdef SPI_TARGET_BURST_EN
    logic [ADDR_W-1:0]   next_addr_s;
    logic [DATA_W-1:0]   next_rd_s;
`endif

    assign shift_next_s = {shift_r[DATA_W-2:0], mosi_lvl_s};
    assign last_rise_s  = sclk_rise_s && (bit_cnt_r == 3'd7) && !done_r;
    // Rise is processed before a same-cycle deselect, so a completed byte still commits.
    assign wr_commit_s  = (state_r == ST_WDATA) && last_rise_s && addr_hit_s;

    // Register-file lookups; unimplemented addresses read as zero.
    always_comb begin
        cmd_rd_s   = 8'h00;
        addr_hit_s = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shift_next_s[ADDR_W-1:0] == ADDR_W'(i)) begin
                cmd_rd_s = regs_r[i];
            end else begin
                cmd_rd_s = cmd_rd_s;
            end
            if (addr_r == ADDR_W'(i)) begin
                addr_hit_s = 1'b1;
            end else begin
                addr_hit_s = addr_hit_s;
            end
        end
    end

`ifdef SPI_TARGET_BURST_EN
    assign next_addr_s = addr_r + 7'd1;

    // Read data for the next address of a burst.
    always_comb begin
        next_rd_s = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (next_addr_s == ADDR_W'(i)) begin
                next_rd_s = regs_r[i];
            end else begin
                next_rd_s = next_rd_s;
            end
        end
    end
`endif

    // Transaction FSM, register file and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 3'd0;
            done_r     <= 1'b0;
            shift_r    <= 8'h00;
            rd_shift_r <= 8'h00;
            addr_r     <= 7'd0;
            miso_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
            wr_pulse_r <= 1'b0;
            wr_addr_r  <= 7'd0;
            wr_data_r  <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL;
            end
        end else begin
            miso_oe_r  <= ~cs_lvl_s;
            wr_pulse_r <= wr_commit_s;
            if (wr_commit_s) begin
                wr_addr_r <= addr_r;
                wr_data_r <= shift_next_s;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr_r == ADDR_W'(i)) begin
                        regs_r[i] <= shift_next_s;
                    end
                end
            end

            if (cs_lvl_s) begin
                state_r    <= ST_IDLE;
                bit_cnt_r  <= 3'd0;
                done_r     <= 1'b0;
                shift_r    <= 8'h00;
                rd_shift_r <= 8'h00;
                miso_r     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        bit_cnt_r <= 3'd0;
                        done_r    <= 1'b0;
                        state_r   <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (sclk_rise_s) begin
                            shift_r   <= shift_next_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                addr_r <= shift_next_s[ADDR_W-1:0];
                                if (shift_next_s[CMD_WRITE_BIT]) begin
                                    state_r <= ST_WDATA;
                                end else begin
                                    state_r    <= ST_RDATA;
                                    rd_shift_r <= cmd_rd_s;
                                    miso_r     <= cmd_rd_s[DATA_W-1];
                                end
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sclk_rise_s && !done_r) begin
                            shift_r   <= shift_next_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
`ifdef SPI_TARGET_BURST_EN
                                addr_r <= next_addr_s;
`else
                                done_r <= 1'b1;
`endif
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (sclk_rise_s && !done_r) begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
`ifdef SPI_TARGET_BURST_EN
                                addr_r     <= next_addr_s;
                                rd_shift_r <= next_rd_s;
                                miso_r     <= next_rd_s[DATA_W-1];
`else
                                done_r <= 1'b1;
`endif
                            end
                        end else if (sclk_fall_s) begin
                            // The fall that follows a byte boundary keeps the freshly loaded MSB.
                            if (done_r) begin
                                miso_r <= 1'b0;
                            end else if (bit_cnt_r != 3'd0) begin
                                rd_shift_r <= {rd_shift_r[DATA_W-2:0], 1'b0};
                                miso_r     <= rd_shift_r[DATA_W-2];
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_r[g];
    end

    assign miso     = miso_r;
    assign miso_oe  = miso_oe_r;
    assign wr_pulse = wr_pulse_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;

endmodule
